// File: rtl/beam_weight_sequencer.sv
// beam_weight_sequencer: table-driven cos/sin weight generator for two beams,
// each sweeping its own index range and updating only on sample strobes.
module beam_weight_sequencer #(
    parameter int DEPTH   = 16,
    parameter int IDX_W   = 4,
    parameter int DWELL_W = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_tbl_wr_en,
    input  logic [IDX_W-1:0]    i_tbl_wr_addr,
    input  logic signed [4:0]   i_tbl_wr_cos,
    input  logic signed [4:0]   i_tbl_wr_sin,
    input  logic                i_cfg_valid,
    output logic                o_cfg_ready,
    input  logic                i_cfg_beam,
    input  logic [IDX_W-1:0]    i_cfg_start,
    input  logic [IDX_W-1:0]    i_cfg_end,
    input  logic [DWELL_W-1:0]  i_cfg_dwell,
    input  logic                i_cfg_sweep,
    input  logic                i_enable,
    input  logic                i_sample_strobe,
    output logic signed [4:0]   o_w_cos_1,
    output logic signed [4:0]   o_w_sin_1,
    output logic signed [4:0]   o_w_cos_2,
    output logic signed [4:0]   o_w_sin_2,
    output logic [IDX_W-1:0]    o_idx_1,
    output logic [IDX_W-1:0]    o_idx_2,
    output logic                o_wrap_1,
    output logic                o_wrap_2
);
    logic signed [4:0]  r_cos [DEPTH];
    logic signed [4:0]  r_sin [DEPTH];
    logic               r_pend, r_sh_beam, r_sh_sweep;
    logic [IDX_W-1:0]   r_sh_start, r_sh_end;
    logic [DWELL_W-1:0] r_sh_dwell;
    logic [IDX_W-1:0]   r_idx [2];
    logic [IDX_W-1:0]   r_start [2];
    logic [IDX_W-1:0]   r_end [2];
    logic [DWELL_W-1:0] r_cnt [2];
    logic [DWELL_W-1:0] r_dwell [2];
    logic               r_sweep [2];
    logic               r_wrap [2];
    logic signed [4:0]  r_wc [2];
    logic signed [4:0]  r_ws [2];
    logic               w_accept;
    logic               w_apply [2];
    logic               w_step [2];
    logic               w_adv [2];
    logic               w_wrap [2];
    logic [IDX_W-1:0]   w_idx_nxt [2];
    logic [DWELL_W-1:0] w_cnt_nxt [2];

    // A config pending before this edge is applied; one accepted on this edge waits for the next strobe.
    always_comb begin
        w_accept = i_cfg_valid & ~r_pend;
        for (int b = 0; b < 2; b++) begin
            w_apply[b]   = i_sample_strobe & r_pend & (r_sh_beam == 1'(b));
            w_step[b]    = i_sample_strobe & i_enable & r_sweep[b] & ~w_apply[b];
            w_adv[b]     = w_step[b] & (r_cnt[b] == r_dwell[b]);
            w_wrap[b]    = w_adv[b] & (r_idx[b] == r_end[b]);
            w_idx_nxt[b] = w_apply[b] ? r_sh_start :
                           w_wrap[b]  ? r_start[b] :
                           w_adv[b]   ? ((r_idx[b] == IDX_W'(DEPTH - 1)) ? '0 : r_idx[b] + 1'b1) :
                                        r_idx[b];
            w_cnt_nxt[b] = (w_apply[b] | w_adv[b]) ? '0 :
                           w_step[b]               ? r_cnt[b] + 1'b1 :
                                                     r_cnt[b];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_cos[i] <= '0;
                r_sin[i] <= '0;
            end
            r_pend     <= 1'b0;
            r_sh_beam  <= 1'b0;
            r_sh_sweep <= 1'b0;
            r_sh_start <= '0;
            r_sh_end   <= '0;
            r_sh_dwell <= '0;
            for (int b = 0; b < 2; b++) begin
                r_idx[b]   <= '0;
                r_start[b] <= '0;
                r_end[b]   <= '0;
                r_cnt[b]   <= '0;
                r_dwell[b] <= '0;
                r_sweep[b] <= 1'b0;
                r_wrap[b]  <= 1'b0;
                r_wc[b]    <= '0;
                r_ws[b]    <= '0;
            end
        end else begin
            if (i_tbl_wr_en) begin
                r_cos[i_tbl_wr_addr] <= i_tbl_wr_cos;
                r_sin[i_tbl_wr_addr] <= i_tbl_wr_sin;
            end
            if (w_accept) begin
                r_pend     <= 1'b1;
                r_sh_beam  <= i_cfg_beam;
                r_sh_start <= i_cfg_start;
                r_sh_end   <= i_cfg_end;
                r_sh_dwell <= i_cfg_dwell;
                r_sh_sweep <= i_cfg_sweep;
            end else if (i_sample_strobe) begin
                r_pend <= 1'b0;
            end
            for (int b = 0; b < 2; b++) begin
                r_idx[b]  <= w_idx_nxt[b];
                r_cnt[b]  <= w_cnt_nxt[b];
                r_wrap[b] <= w_wrap[b];
                if (w_apply[b]) begin
                    r_start[b] <= r_sh_start;
                    r_end[b]   <= r_sh_end;
                    r_dwell[b] <= r_sh_dwell;
                    r_sweep[b] <= r_sh_sweep;
                end
                // Table read sees pre-write contents, so a same-cycle write shows up one strobe later.
                if (i_sample_strobe) begin
                    r_wc[b] <= r_cos[w_idx_nxt[b]];
                    r_ws[b] <= r_sin[w_idx_nxt[b]];
                end
            end
        end
    end

    assign o_cfg_ready = ~r_pend;
    assign o_w_cos_1   = r_wc[0];
    assign o_w_sin_1   = r_ws[0];
    assign o_w_cos_2   = r_wc[1];
    assign o_w_sin_2   = r_ws[1];
    assign o_idx_1     = r_idx[0];
    assign o_idx_2     = r_idx[1];
    assign o_wrap_1    = r_wrap[0];
    assign o_wrap_2    = r_wrap[1];
endmodule

// File: tb/tb_beam_weight_sequencer.sv
// tb_beam_weight_sequencer: directed stimulus with a strobe-driven scoreboard
// plus direct checks of reset, handshake and pulse width.
module tb_beam_weight_sequencer;
    logic              clk, rst_n;
    logic              tbl_wr_en, cfg_valid, cfg_ready, cfg_beam, cfg_sweep, enable, strobe;
    logic [3:0]        tbl_wr_addr, cfg_start, cfg_end, idx_1, idx_2;
    logic signed [4:0] tbl_wr_cos, tbl_wr_sin, w_cos_1, w_sin_1, w_cos_2, w_sin_2;
    logic [15:0]       cfg_dwell;
    logic              wrap_1, wrap_2;

    typedef struct packed {
        logic [3:0]        i1;
        logic signed [4:0] c1;
        logic signed [4:0] s1;
        logic [3:0]        i2;
        logic signed [4:0] c2;
        logic signed [4:0] s2;
        logic              r1;
        logic              r2;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   nstrobe = 0;

    beam_weight_sequencer dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_tbl_wr_en(tbl_wr_en), .i_tbl_wr_addr(tbl_wr_addr),
        .i_tbl_wr_cos(tbl_wr_cos), .i_tbl_wr_sin(tbl_wr_sin),
        .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready), .i_cfg_beam(cfg_beam),
        .i_cfg_start(cfg_start), .i_cfg_end(cfg_end), .i_cfg_dwell(cfg_dwell),
        .i_cfg_sweep(cfg_sweep), .i_enable(enable), .i_sample_strobe(strobe),
        .o_w_cos_1(w_cos_1), .o_w_sin_1(w_sin_1), .o_w_cos_2(w_cos_2), .o_w_sin_2(w_sin_2),
        .o_idx_1(idx_1), .o_idx_2(idx_2), .o_wrap_1(wrap_1), .o_wrap_2(wrap_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(int i1, int c1, int s1, int i2, int c2, int s2, int r1, int r2);
        exp_t e;
        e.i1 = 4'(i1); e.c1 = 5'(c1); e.s1 = 5'(s1);
        e.i2 = 4'(i2); e.c2 = 5'(c2); e.s2 = 5'(s2);
        e.r1 = 1'(r1); e.r2 = 1'(r2);
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every strobe edge produces a new output set, compared 1 time unit later.
    always @(posedge clk) begin
        if (rst_n && strobe) begin
            exp_t a, e;
            #1;
            nstrobe++;
            a = {idx_1, w_cos_1, w_sin_1, idx_2, w_cos_2, w_sin_2, wrap_1, wrap_2};
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL strobe%0d: output with no expectation queued", nstrobe);
            end else begin
                e = q.pop_front();
                if (a != e) begin
                    failures++;
                    $display("FAIL strobe%0d: got idx1=%0d c1=%0d s1=%0d idx2=%0d c2=%0d s2=%0d wr=%b%b expected idx1=%0d c1=%0d s1=%0d idx2=%0d c2=%0d s2=%0d wr=%b%b",
                             nstrobe, a.i1, a.c1, a.s1, a.i2, a.c2, a.s2, a.r1, a.r2,
                             e.i1, e.c1, e.s1, e.i2, e.c2, e.s2, e.r1, e.r2);
                end
            end
        end
    end

    task automatic sstep(input exp_t e);
        q.push_back(e);
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
    endtask

    task automatic wr(input int a, input int c, input int s);
        tbl_wr_en = 1'b1; tbl_wr_addr = 4'(a); tbl_wr_cos = 5'(c); tbl_wr_sin = 5'(s);
        @(negedge clk);
        tbl_wr_en = 1'b0;
    endtask

    task automatic set_cfg(input int b, input int s, input int e, input int d, input int sw);
        cfg_beam = 1'(b); cfg_start = 4'(s); cfg_end = 4'(e); cfg_dwell = 16'(d); cfg_sweep = 1'(sw);
    endtask

    task automatic cfg(input int b, input int s, input int e, input int d, input int sw);
        set_cfg(b, s, e, d, sw);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    int seq2 [7] = '{2, 2, 3, 3, 4, 4, 2};

    initial begin
        rst_n = 1'b0; tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_cos = '0; tbl_wr_sin = '0;
        cfg_valid = 1'b0; enable = 1'b0; strobe = 1'b0;
        set_cfg(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", int'(cfg_ready), 1);
        chk("rst_idx1", int'(idx_1), 0);
        chk("rst_idx2", int'(idx_2), 0);
        chk("rst_wcos1", int'(w_cos_1), 0);
        chk("rst_wsin2", int'(w_sin_2), 0);
        sstep(mk(0, 0, 0, 0, 0, 0, 0, 0));
        sstep(mk(0, 0, 0, 0, 0, 0, 0, 0));

        // hold mode on beam 1
        wr(3, 15, -16);
        cfg(0, 3, 3, 0, 0);
        chk("hold_ready_pending", int'(cfg_ready), 0);
        sstep(mk(3, 15, -16, 0, 0, 0, 0, 0));
        chk("hold_ready_after_apply", int'(cfg_ready), 1);
        sstep(mk(3, 15, -16, 0, 0, 0, 0, 0));

        // sweep 2..4 with dwell 1 on beam 2
        for (int i = 0; i < 16; i++) wr(i, i, -i);
        cfg(1, 2, 4, 1, 1);
        enable = 1'b1;
        for (int k = 0; k < 7; k++)
            sstep(mk(3, 3, -3, seq2[k], seq2[k], -seq2[k], 0, (k == 6) ? 1 : 0));
        @(negedge clk);
        chk("wrap2_one_cycle", int'(wrap_2), 0);

        // enable freeze keeps dwell count
        sstep(mk(3, 3, -3, 2, 2, -2, 0, 0));
        enable = 1'b0;
        for (int k = 0; k < 5; k++) sstep(mk(3, 3, -3, 2, 2, -2, 0, 0));
        enable = 1'b1;
        sstep(mk(3, 3, -3, 3, 3, -3, 0, 0));

        // park beam 2, then sweep beam 1 through the top of the table
        cfg(1, 5, 5, 0, 0);
        sstep(mk(3, 3, -3, 5, 5, -5, 0, 0));
        cfg(0, 14, 1, 0, 1);
        sstep(mk(14, 14, -14, 5, 5, -5, 0, 0));
        sstep(mk(15, 15, -15, 5, 5, -5, 0, 0));
        sstep(mk(0, 0, 0, 5, 5, -5, 0, 0));
        sstep(mk(1, 1, -1, 5, 5, -5, 0, 0));
        sstep(mk(14, 14, -14, 5, 5, -5, 1, 0));

        // config accepted on a strobe cycle applies only at the next strobe
        set_cfg(1, 7, 9, 0, 1);
        cfg_valid = 1'b1;
        sstep(mk(15, 15, -15, 5, 5, -5, 0, 0));
        cfg_valid = 1'b0;
        chk("simul_ready", int'(cfg_ready), 0);
        set_cfg(1, 10, 10, 0, 0);
        cfg_valid = 1'b1;
        @(negedge clk);
        chk("stall_ready1", int'(cfg_ready), 0);
        @(negedge clk);
        chk("stall_ready2", int'(cfg_ready), 0);
        cfg_valid = 1'b0;
        sstep(mk(0, 0, 0, 7, 7, -7, 0, 0));
        chk("simul_ready_after", int'(cfg_ready), 1);
        sstep(mk(1, 1, -1, 8, 8, -8, 0, 0));

        // table write racing a strobe read of the same entry
        enable = 1'b0;
        tbl_wr_en = 1'b1; tbl_wr_addr = 4'd8; tbl_wr_cos = -5'sd7; tbl_wr_sin = 5'sd6;
        sstep(mk(1, 1, -1, 8, 8, -8, 0, 0));
        tbl_wr_en = 1'b0;
        sstep(mk(1, 1, -1, 8, -7, 6, 0, 0));

        // asynchronous reset between edges with a config pending
        enable = 1'b1;
        cfg(0, 4, 4, 0, 0);
        chk("pre_rst_ready", int'(cfg_ready), 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_ready", int'(cfg_ready), 1);
        chk("arst_idx1", int'(idx_1), 0);
        chk("arst_idx2", int'(idx_2), 0);
        chk("arst_wcos2", int'(w_cos_2), 0);
        chk("arst_wsin2", int'(w_sin_2), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sstep(mk(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("sb_drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
